// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the single-port SRAM arbiter.
// SRAM_ARB_FAIR_EN (in sram_arb_grant) switches between fixed write priority and round-robin.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int PHASE_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational winner pick between the record (write) and playback (read) requesters.
// Define SRAM_ARB_FAIR_EN for round-robin on contention; otherwise writes always win.
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic   wr_req_i,
    input  logic   rd_req_i,
    input  grant_e last_grant_i,
    output logic   grant_o,
    output grant_e winner_o
);

`ifdef SRAM_ARB_FAIR_EN
    // On contention the side that did not win last time goes next.
    always_comb begin
        grant_o  = wr_req_i | rd_req_i;
        winner_o = GRANT_WR;
        if (wr_req_i && rd_req_i) begin
            winner_o = (last_grant_i == GRANT_RD) ? GRANT_WR : GRANT_RD;
        end else if (rd_req_i) begin
            winner_o = GRANT_RD;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_grant_i;

    // Recording must never drop samples, so a pending write always wins.
    always_comb begin
        grant_o  = wr_req_i | rd_req_i;
        winner_o = wr_req_i ? GRANT_WR : GRANT_RD;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM sequencer: serializes record writes and playback reads into fixed-length
// strobe windows, each followed by an IDLE turnaround cycle. Arbitration mode: SRAM_ARB_FAIR_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_req,
    input  logic [SRAM_ADDR_W-1:0] i_wr_addr,
    input  logic [SRAM_DATA_W-1:0] i_wr_data,
    output logic                   o_wr_ack,
    input  logic                   i_rd_req,
    input  logic [SRAM_ADDR_W-1:0] i_rd_addr,
    output logic [SRAM_DATA_W-1:0] o_rd_data,
    output logic                   o_rd_valid,
    output logic [SRAM_ADDR_W-1:0] o_sram_addr,
    inout  wire  [SRAM_DATA_W-1:0] io_sram_dq,
    output logic                   o_sram_we_n,
    output logic                   o_sram_oe_n,
    output logic                   o_sram_ce_n,
    output logic                   o_sram_lb_n,
    output logic                   o_sram_ub_n,
    output state_e                 o_dbg_state
);

    localparam logic [PHASE_W-1:0] WR_LOAD = PHASE_W'(WR_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RD_LOAD = PHASE_W'(RD_CYCLES - 1);

    state_e                 state_q;
    logic [PHASE_W-1:0]     cnt_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [SRAM_DATA_W-1:0] wdata_q;
    logic [SRAM_DATA_W-1:0] rd_data_q;
    logic                   wr_ack_q;
    logic                   rd_valid_q;
    logic                   we_n_q;
    logic                   oe_n_q;
    grant_e                 last_grant_q;

    logic                   rd_req_d;
    logic                   grant_d;
    grant_e                 winner_d;

    // The read requester only drops its level in the cycle of o_rd_valid, so ignore it then.
    assign rd_req_d = i_rd_req & ~rd_valid_q;

    sram_arb_grant u_grant (
        .wr_req_i     (i_wr_req),
        .rd_req_i     (rd_req_d),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_d),
        .winner_o     (winner_d)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            wr_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            last_grant_q <= GRANT_RD;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        last_grant_q <= winner_d;
                        if (winner_d == GRANT_WR) begin
                            state_q  <= WRITE;
                            addr_q   <= i_wr_addr;
                            wdata_q  <= i_wr_data;
                            we_n_q   <= 1'b0;
                            cnt_q    <= WR_LOAD;
                            wr_ack_q <= (WR_LOAD == '0);
                        end else begin
                            state_q <= READ;
                            addr_q  <= i_rd_addr;
                            oe_n_q  <= 1'b0;
                            cnt_q   <= RD_LOAD;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q - 1'b1;
                        wr_ack_q <= (cnt_q == PHASE_W'(1));
                    end
                end
                READ: begin
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        oe_n_q     <= 1'b1;
                        rd_data_q  <= io_sram_dq;
                        rd_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_sram_dq  = (state_q == WRITE) ? wdata_q : {SRAM_DATA_W{1'bz}};
    assign o_sram_addr = addr_q;
    assign o_sram_we_n = we_n_q;
    assign o_sram_oe_n = oe_n_q;
    assign o_sram_ce_n = 1'b0;
    assign o_sram_lb_n = 1'b0;
    assign o_sram_ub_n = 1'b0;
    assign o_wr_ack    = wr_ack_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: random request rounds, a transaction-level reference
// model with an SRAM array, plus a WR_CYCLES=1 / RD_CYCLES=4 instance for latency checks.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int WRC = 2;
    localparam int RDC = 2;
`ifdef SRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct packed {
        logic        is_rd;
        logic [19:0] addr;
        logic [15:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance
    logic        wr_req, rd_req, wr_ack, rd_valid;
    logic [19:0] wr_addr, rd_addr, sram_addr;
    logic [15:0] wr_data, rd_data;
    logic        we_n, oe_n, ce_n, lb_n, ub_n;
    state_e      dbg_state;
    wire  [15:0] dq;

    // fast instance
    logic        f_wr_req, f_rd_req, f_wr_ack, f_rd_valid;
    logic [19:0] f_wr_addr, f_rd_addr, f_sram_addr;
    logic [15:0] f_wr_data, f_rd_data;
    logic        f_we_n, f_oe_n, f_ce_n, f_lb_n, f_ub_n;
    state_e      f_state;
    wire  [15:0] f_dq;

    sram_arbiter #(.WR_CYCLES(WRC), .RD_CYCLES(RDC)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_sram_addr(sram_addr), .io_sram_dq(dq),
        .o_sram_we_n(we_n), .o_sram_oe_n(oe_n), .o_sram_ce_n(ce_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n), .o_dbg_state(dbg_state)
    );

    sram_arbiter #(.WR_CYCLES(1), .RD_CYCLES(4)) u_fast (
        .i_clk(clk), .i_rst(rst),
        .i_wr_req(f_wr_req), .i_wr_addr(f_wr_addr), .i_wr_data(f_wr_data), .o_wr_ack(f_wr_ack),
        .i_rd_req(f_rd_req), .i_rd_addr(f_rd_addr), .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid),
        .o_sram_addr(f_sram_addr), .io_sram_dq(f_dq),
        .o_sram_we_n(f_we_n), .o_sram_oe_n(f_oe_n), .o_sram_ce_n(f_ce_n),
        .o_sram_lb_n(f_lb_n), .o_sram_ub_n(f_ub_n), .o_dbg_state(f_state)
    );

    // external SRAM models (64 words are enough for the address range used)
    logic [15:0] sram_mem [0:63];
    always @(posedge clk) if (!we_n) sram_mem[sram_addr[5:0]] <= dq;
    assign dq   = (!oe_n && we_n) ? sram_mem[sram_addr[5:0]] : 16'hzzzz;
    assign f_dq = (!f_oe_n && f_we_n) ? 16'h3C5A : 16'hzzzz;

    logic [15:0] ref_mem [0:63];
    txn_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        model_last_rd = 1'b1;

    logic [19:0] wr_a [0:3];
    logic [15:0] wr_d [0:3];
    logic [19:0] rd_a [0:3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we_n"}, 32'(we_n), 32'd1);
        check({tag, "_oe_n"}, 32'(oe_n), 32'd1);
        check({tag, "_ce_lb_ub"}, {29'd0, ce_n, lb_n, ub_n}, 32'd0);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_ack_valid"}, {30'd0, wr_ack, rd_valid}, 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // monitor: pops the scoreboard on every ack/valid and checks strobe shape
    int   we_run = 0, oe_run = 0, last_oe_run = 0;
    logic prev_we_n = 1'b1, prev_oe_n = 1'b1;
    txn_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            we_run = 0; oe_run = 0; prev_we_n = 1'b1; prev_oe_n = 1'b1;
        end else begin
            if (!we_n) we_run++; else we_run = 0;
            if (!oe_n) oe_run++;
            else if (oe_run != 0) begin last_oe_run = oe_run; oe_run = 0; end
            if ((!we_n && we_run == 1) || (!oe_n && oe_run == 1)) begin
                n_cmp++;
                if (!prev_we_n || !prev_oe_n || (!we_n && !oe_n)) begin
                    n_fail++;
                    $display("FAIL turnaround: strobe started with prev we_n=%b oe_n=%b now we_n=%b oe_n=%b",
                             prev_we_n, prev_oe_n, we_n, oe_n);
                end
            end
            if (wr_ack) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_ack: got ack expected none at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_kind", 32'(mon_e.is_rd), 32'd0);
                    check("ack_we_low", 32'(we_n), 32'd0);
                    check("wr_run_len", 32'(we_run), 32'(WRC));
                    check("wr_addr", 32'(sram_addr), 32'(mon_e.addr));
                    check("wr_dq", 32'(dq), 32'(mon_e.data));
                end
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_valid: got valid expected none at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid_kind", 32'(mon_e.is_rd), 32'd1);
                    check("rd_data", 32'(rd_data), 32'(mon_e.data));
                    check("rd_addr", 32'(sram_addr), 32'(mon_e.addr));
                    check("rd_run_len", {31'd0, prev_oe_n}, 32'd0);
                    check("oe_run_len", 32'(last_oe_run), 32'(RDC));
                end
            end
            prev_we_n = we_n;
            prev_oe_n = oe_n;
        end
    end

    // issues nw writes and nr reads (from wr_a/wr_d/rd_a), all raised together from IDLE
    task automatic run_round(input int nw, input int nr);
        int   wi, ri, cyc;
        logic pick_rd;
        txn_t e;
        wi = 0; ri = 0;
        while (wi < nw || ri < nr) begin
            if (wi < nw && ri < nr) pick_rd = FAIR ? !model_last_rd : 1'b0;
            else                    pick_rd = (ri < nr);
            if (pick_rd) begin
                e = '{is_rd: 1'b1, addr: rd_a[ri], data: ref_mem[rd_a[ri][5:0]]};
                ri++;
            end else begin
                e = '{is_rd: 1'b0, addr: wr_a[wi], data: wr_d[wi]};
                ref_mem[wr_a[wi][5:0]] = wr_d[wi];
                wi++;
            end
            model_last_rd = pick_rd;
            exp_q.push_back(e);
        end
        wi = 0; ri = 0; cyc = 0;
        wr_req = (nw > 0); wr_addr = wr_a[0]; wr_data = wr_d[0];
        rd_req = (nr > 0); rd_addr = rd_a[0];
        while ((wi < nw || ri < nr) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wr_ack && wi < nw) begin
                wi++;
                if (wi < nw) begin wr_addr = wr_a[wi]; wr_data = wr_d[wi]; end
                else wr_req = 1'b0;
            end
            if (rd_valid && ri < nr) begin
                ri++;
                if (ri < nr) rd_addr = rd_a[ri];
                else rd_req = 1'b0;
            end
        end
        if (wi < nw || ri < nr) begin
            n_cmp++; n_fail++;
            $display("FAIL round_timeout: got %0d/%0d done expected %0d/%0d", wi, ri, nw, nr);
            wr_req = 1'b0; rd_req = 1'b0;
            exp_q.delete();
        end else if (nr == 0) begin
            check("wr_round_cycles", 32'(cyc), 32'(nw * (WRC + 1) - 1));
        end else if (nw == 0) begin
            check("rd_round_cycles", 32'(cyc), 32'(nr * (RDC + 2) - 1));
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_count(input string name, ref logic sig, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!sig && cnt < 20);
        if (!sig) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got no pulse expected one within 20 cycles", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected one before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nr, cnt, oe_low;
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = 16'(i * 16'h0101 ^ 16'h1234);
            ref_mem[i]  = 16'(i * 16'h0101 ^ 16'h1234);
        end
        rst = 1'b1;
        wr_req = 0; rd_req = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
        f_wr_req = 0; f_rd_req = 0; f_wr_addr = 0; f_rd_addr = 0; f_wr_data = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // directed: single write, read back, simultaneous pair, held write, held pair
        wr_a[0] = 20'h00010; wr_d[0] = 16'hA5A5; run_round(1, 0);
        rd_a[0] = 20'h00010;                     run_round(0, 1);
        wr_a[0] = 20'h00012; wr_d[0] = 16'h0F0F; rd_a[0] = 20'h00010; run_round(1, 1);
        wr_a[0] = 20'h00010; wr_d[0] = 16'h1111;
        wr_a[1] = 20'h00011; wr_d[1] = 16'h2222; run_round(2, 0);
        wr_a[0] = 20'h00013; wr_d[0] = 16'h3333; wr_a[1] = 20'h00014; wr_d[1] = 16'h4444;
        rd_a[0] = 20'h00011; rd_a[1] = 20'h00013; run_round(2, 2);

        for (int r = 0; r < 30; r++) begin
            nw = $urandom_range(0, 3);
            nr = $urandom_range(0, 3);
            if (nw == 0 && nr == 0) nw = 1;
            for (int k = 0; k < 4; k++) begin
                wr_a[k] = 20'($urandom_range(0, 63));
                wr_d[k] = 16'($urandom);
                rd_a[k] = 20'($urandom_range(0, 63));
            end
            run_round(nw, nr);
        end

        // WR_CYCLES=1 / RD_CYCLES=4 latency
        f_wr_req = 1'b1; f_wr_addr = 20'h00005; f_wr_data = 16'hBEEF;
        wait_count("fast_ack", f_wr_ack, cnt);
        check("fast_ack_latency", 32'(cnt), 32'd1);
        check("fast_wr_dq", 32'(f_dq), 32'hBEEF);
        f_wr_req = 1'b0;
        repeat (2) @(negedge clk);
        f_rd_req = 1'b1; f_rd_addr = 20'h00005;
        cnt = 0; oe_low = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (!f_oe_n) oe_low++;
        end while (!f_rd_valid && cnt < 20);
        f_rd_req = 1'b0;
        check("fast_valid_latency", 32'(cnt), 32'd5);
        check("fast_oe_low_cycles", 32'(oe_low), 32'd4);
        check("fast_rd_data", 32'(f_rd_data), 32'h3C5A);

        // reset in the first WRITE cycle
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 20'h00020; wr_data = 16'h5A5A;
        @(negedge clk);
        check("abort_we_low", 32'(we_n), 32'd0);
        rst = 1'b1; wr_req = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_we_stays_high", 32'(we_n), 32'd1);
        check("abort_no_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
